// File: rtl/cpc_io_bus_mux.sv
// N-channel CPU I/O bus multiplexer: it decodes addresses, issues one-clk access strobes,
// waits for the peripheral ready handshake, and times out an access that is never answered.
module cpc_io_bus_mux #(
  parameter int                       CHANNELS  = 4,
  parameter logic [16*CHANNELS-1:0]   DEC_MASK  = {CHANNELS{16'h0000}},
  parameter logic [16*CHANNELS-1:0]   DEC_MATCH = {CHANNELS{16'hFFFF}},
  parameter int                       TIMEOUT   = 63
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ce,
  input  logic                    io_rd,
  input  logic                    io_wr,
  input  logic [15:0]             cpu_addr,
  input  logic [7:0]              cpu_dout,
  output logic [7:0]              cpu_din,
  output logic                    wait_n,
  output logic [CHANNELS-1:0]     ch_rd_stb,
  output logic [CHANNELS-1:0]     ch_wr_stb,
  output logic [7:0]              ch_wdata,
  output logic [15:0]             ch_addr,
  input  logic [8*CHANNELS-1:0]   ch_rdata,
  input  logic [CHANNELS-1:0]     ch_ready,
  output logic                    timeout_flag,
  output logic [1:0]              dbg_state
);

  // Handshake: a level io_rd/io_wr sampled in IDLE with ce=1 is the request. Each selected
  // channel answers with a level ch_ready. wait_n stays low from the strobe cycle until
  // the clk after every selected channel is ready, or until the timeout expires.
  // dbg_state encoding: 0 = IDLE, 1 = ACCESS, 2 = HOLD.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] TO_SAT  = 8'(TIMEOUT);

  state_t              state;
  logic [CHANNELS-1:0] sel_q;
  logic                is_rd_q;
  logic [7:0]          wait_cnt;

  logic [CHANNELS-1:0] hit;
  logic [7:0]          rd_and;
  logic                all_ready;

  always_comb begin
    hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hit[i] = ((cpu_addr & DEC_MASK[16*i +: 16]) == DEC_MATCH[16*i +: 16]);
    end
  end

  // Read buses of all selected peripherals are wired-AND, as on the original board.
  always_comb begin
    rd_and = 8'hFF;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel_q[i]) begin
        rd_and = rd_and & ch_rdata[8*i +: 8];
      end
    end
  end

  assign all_ready = &(ch_ready | ~sel_q);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_HOLD;
      cpu_din      <= 8'hFF;
      wait_n       <= 1'b1;
      ch_rd_stb    <= '0;
      ch_wr_stb    <= '0;
      ch_wdata     <= 8'h00;
      ch_addr      <= 16'h0000;
      timeout_flag <= 1'b0;
      wait_cnt     <= 8'h00;
      sel_q        <= '0;
      is_rd_q      <= 1'b0;
    end else begin
      ch_rd_stb <= '0;
      ch_wr_stb <= '0;
      case (state)
        ST_HOLD: begin
          if (!io_rd && !io_wr) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (ce && (io_rd || io_wr)) begin
            if (io_rd && io_wr) begin
              state <= ST_HOLD;
            end else if (hit == '0) begin
              // Unmapped access: finish at once, floating bus reads back as FF.
              state <= ST_HOLD;
              if (io_rd) begin
                cpu_din <= 8'hFF;
              end
            end else begin
              state     <= ST_ACCESS;
              ch_addr   <= cpu_addr;
              ch_wdata  <= cpu_dout;
              sel_q     <= hit;
              is_rd_q   <= io_rd;
              ch_rd_stb <= io_rd ? hit : '0;
              ch_wr_stb <= io_wr ? hit : '0;
              wait_n    <= 1'b0;
              wait_cnt  <= 8'h00;
            end
          end
        end
        ST_ACCESS: begin
          if (all_ready) begin
            state  <= ST_HOLD;
            wait_n <= 1'b1;
            if (is_rd_q) begin
              cpu_din <= rd_and;
            end
          end else if (ce) begin
            if (wait_cnt >= TO_LAST) begin
              state        <= ST_HOLD;
              wait_n       <= 1'b1;
              wait_cnt     <= TO_SAT;
              timeout_flag <= 1'b1;
              if (is_rd_q) begin
                cpu_din <= 8'hFF;
              end
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule
